pipe_scoreboard: RTL
====================

Name: pipe_scoreboard

Overview:
- Parametrised successor to the fixed load-use hazard detector and two-source forwarding unit in the 5-stage core.
- Tracks every architectural register with a per-register busy flag, a result-ready countdown and an issue age. From these it produces decode-stage stall, bypass-ready indications and wrong-path cleanup on branch/jump redirect.
- Supports variable-latency producers: ALU, load, and multi-cycle units such as a future MUL/DIV.
- Sits beside the decode stage; the core's hazard and forwarding instances are replaced by it.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked busy
REG_IDX_W, 5, register index width; must satisfy 2**REG_IDX_W >= NUM_REGS
LAT_W, 3, width of latency field and per-entry countdown
FLUSH_DEPTH, 2, entries issued fewer than this many cycles before a redirect are wrong-path and are cleared
CNT_W, 6, width of busy_count_out; must satisfy 2**CNT_W > NUM_REGS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  decode holds a valid instruction
id_rs1  in  REG_IDX_W  source 1 index
id_rs1_used  in  1  instruction reads rs1
id_rs2  in  REG_IDX_W  source 2 index
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_IDX_W  destination index
id_rd_we  in  1  instruction writes rd
id_lat  in  LAT_W  producer latency; 0 = unknown, cleared only by writeback
ext_stall_in  in  1  stall from elsewhere, e.g. memory not ready
redirect_in  in  1  taken branch/jump resolved (PCSrc)
wb_valid  in  1  register-file write this cycle
wb_rd  in  REG_IDX_W  written register
issue_out  out  1  decode instruction advances to execute this cycle
stall_out  out  1  hold PC and IF/ID
flush_out  out  1  kill IF/ID and ID/EX contents
fwd_rs1_out  out  1  rs1 must come from the bypass network
fwd_rs2_out  out  1  rs2 must come from the bypass network
busy_count_out  out  CNT_W  registered count of busy entries

Behaviour:
- Reset (rst low, asynchronous): all busy, cnt, hold and age cleared; busy_count_out=0. While in reset, issue_out, stall_out, flush_out and the fwd outputs are 0. Reset mid-operation discards all entries with no drain.
- Per entry r (1..NUM_REGS-1): busy, cnt[LAT_W], hold, age (saturating at FLUSH_DEPTH).
- Source readiness (combinational, rs used and index != 0):
  - ready if not busy, or if busy with cnt==0 and hold==0;
  - ready if wb_valid && wb_rd==rs, because the register file writes through.
- fwd_rsN_out = rsN used && rsN!=0 && busy && cnt==0 && !hold && !(wb_valid && wb_rd==rsN).
- WAW hazard: id_rd_we && id_rd!=0 && busy[id_rd] && (cnt!=0 || hold). The instruction must wait.
- stall_out = id_valid && (any source not ready || WAW || ext_stall_in) && !redirect_in.
- flush_out = redirect_in; a redirect takes priority over stall.
- issue_out = id_valid && !stall_out && !redirect_in.
- Each clock edge, in priority order (lowest to highest):
  1. Every busy entry with cnt!=0 and !hold decrements cnt. Every busy entry's age increments, saturating.
  2. If wb_valid && wb_rd!=0: clear busy[wb_rd].
  3. If redirect_in: clear every busy entry with age < FLUSH_DEPTH. Older entries persist.
  4. If issue_out && id_rd_we && id_rd!=0: busy=1, age=0.
     - id_lat!=0: cnt=id_lat-1, hold=0.
     - id_lat==0: cnt=all-ones, hold=1.
     - This step overrides a same-cycle writeback to the same rd.
- Latency rule: a producer with id_lat=L lets a dependent issue exactly L cycles after it, i.e. L-1 stall bubbles. ALU L=1 gives 0 bubbles; load L=2 gives 1 bubble.
- busy_count_out: registered population count of the next-state busy vector. It is valid one cycle after the change.
- Writes to register 0 and reads of register 0 never stall and never forward.

Test Plan:
- ALU chain: issue add x5 (lat 1), next cycle add x6,x5,x5 -> no stall; fwd_rs1_out=fwd_rs2_out=1; busy_count_out=1 then 2.
- Load-use: issue lw x7 (lat 2), next cycle dependent on x7 -> stall_out=1 for exactly 1 cycle, then issue with fwd_rs1_out=1.
- Long-latency: issue div x9 (lat 0), dependent waits -> stall_out held for 10 cycles. With wb_valid, wb_rd=9 that cycle -> issue_out=1, fwd_rs1_out=0.
- Redirect: issue x10 at cycle t, x11 at t+3; redirect_in at t+4 -> flush_out=1, issue_out=0. x11 is cleared and x10 persists; busy_count_out drops from 2 to 1.
- Simultaneous issue and writeback to x12 in the same cycle -> x12 stays busy with the new latency. A write or read of x0 -> never stalls.
- Assert rst low while 3 entries are busy -> busy_count_out=0 and all outputs 0 immediately. After release, a dependent instruction issues without stalling.

Source files
------------

// File: rtl/pipe_scoreboard.sv
// Register scoreboard beside decode: per-register busy/countdown/age tracking that drives
// decode stall, bypass selection and wrong-path cleanup on redirect.
module pipe_scoreboard #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned REG_IDX_W   = 5,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic                 id_rs1_used,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_rd_we,
    input  logic [LAT_W-1:0]     id_lat,
    input  logic                 ext_stall_in,
    input  logic                 redirect_in,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic                 issue_out,
    output logic                 stall_out,
    output logic                 flush_out,
    output logic                 fwd_rs1_out,
    output logic                 fwd_rs2_out,
    output logic [CNT_W-1:0]     busy_count_out
);

    localparam int unsigned NSLOT = 2 ** REG_IDX_W;
    localparam int unsigned AGE_W = $clog2(FLUSH_DEPTH + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(FLUSH_DEPTH);

    logic [NSLOT-1:0] busy_q, busy_d, hold_q, hold_d;
    logic [LAT_W-1:0] cnt_q [NSLOT];
    logic [LAT_W-1:0] cnt_d [NSLOT];
    logic [AGE_W-1:0] age_q [NSLOT];
    logic [AGE_W-1:0] age_d [NSLOT];
    logic [CNT_W-1:0] busy_count_q, busy_count_d;

    logic rs1_chk, rs1_busy, rs1_pend, rs1_wb, rs1_ok, fwd1;
    logic rs2_chk, rs2_busy, rs2_pend, rs2_wb, rs2_ok, fwd2;
    logic waw, stall, issue;

    // A busy entry with an expired countdown is sitting in the bypass network.
    always_comb begin
        rs1_chk  = id_rs1_used && (id_rs1 != '0);
        rs1_busy = busy_q[id_rs1];
        rs1_pend = (cnt_q[id_rs1] != '0) || hold_q[id_rs1];
        rs1_wb   = wb_valid && (wb_rd == id_rs1);
        rs1_ok   = !rs1_chk || !rs1_busy || !rs1_pend || rs1_wb;
        fwd1     = rs1_chk && rs1_busy && !rs1_pend && !rs1_wb;

        rs2_chk  = id_rs2_used && (id_rs2 != '0);
        rs2_busy = busy_q[id_rs2];
        rs2_pend = (cnt_q[id_rs2] != '0) || hold_q[id_rs2];
        rs2_wb   = wb_valid && (wb_rd == id_rs2);
        rs2_ok   = !rs2_chk || !rs2_busy || !rs2_pend || rs2_wb;
        fwd2     = rs2_chk && rs2_busy && !rs2_pend && !rs2_wb;

        waw   = id_rd_we && (id_rd != '0) && busy_q[id_rd]
                && ((cnt_q[id_rd] != '0) || hold_q[id_rd]);
        stall = id_valid && (!rs1_ok || !rs2_ok || waw || ext_stall_in) && !redirect_in;
        issue = id_valid && !stall && !redirect_in;
    end

    assign issue_out      = rst && issue;
    assign stall_out      = rst && stall;
    assign flush_out      = rst && redirect_in;
    assign fwd_rs1_out    = rst && fwd1;
    assign fwd_rs2_out    = rst && fwd2;
    assign busy_count_out = busy_count_q;

    // Later steps override earlier ones: countdown/age, writeback, redirect, new issue.
    always_comb begin
        busy_count_d = '0;
        for (int unsigned r = 0; r < NSLOT; r++) begin
            busy_d[r] = busy_q[r];
            hold_d[r] = hold_q[r];
            cnt_d[r]  = cnt_q[r];
            age_d[r]  = age_q[r];
            if (busy_q[r]) begin
                if ((cnt_q[r] != '0) && !hold_q[r]) cnt_d[r] = cnt_q[r] - 1'b1;
                if (age_q[r] < AGE_MAX) age_d[r] = age_q[r] + 1'b1;
            end
            if (wb_valid && (wb_rd == REG_IDX_W'(r))) busy_d[r] = 1'b0;
            if (redirect_in && busy_q[r] && (age_q[r] < AGE_MAX)) busy_d[r] = 1'b0;
            if (issue && id_rd_we && (id_rd == REG_IDX_W'(r))) begin
                busy_d[r] = 1'b1;
                age_d[r]  = '0;
                if (id_lat != '0) begin
                    cnt_d[r]  = id_lat - 1'b1;
                    hold_d[r] = 1'b0;
                end else begin
                    cnt_d[r]  = '1;
                    hold_d[r] = 1'b1;
                end
            end
            if ((r == 0) || (r >= NUM_REGS)) begin
                busy_d[r] = 1'b0;
                hold_d[r] = 1'b0;
                cnt_d[r]  = '0;
                age_d[r]  = '0;
            end
            busy_count_d = busy_count_d + CNT_W'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q       <= '0;
            hold_q       <= '0;
            busy_count_q <= '0;
            for (int unsigned r = 0; r < NSLOT; r++) begin
                cnt_q[r] <= '0;
                age_q[r] <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            hold_q       <= hold_d;
            busy_count_q <= busy_count_d;
            for (int unsigned r = 0; r < NSLOT; r++) begin
                cnt_q[r] <= cnt_d[r];
                age_q[r] <= age_d[r];
            end
        end
    end

endmodule
